weight_fetch_ctrl: RTL and testbench

- Sequences one weight BRAM (DEPTH x DW, negedge-clocked, read-first-or-write, 1 address/cycle) for the ANN datapath.
- Arbitrates BRAM access between two requesters: the neuron compute engine, which issues burst reads of all DEPTH weights in address order, and the weight loader, which issues single-word writes.
- Presents read weights as a valid-qualified, index-tagged stream with a last flag.
- Sits between the layer scheduler/MAC and one Weight_x_y_z BRAM instance.

---
 rtl/weight_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM sequencer. It arbitrates between full-depth burst reads for the MAC
// and single-word writes from the weight loader.
module weight_fetch_ctrl #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    output logic [AW-1:0] W_IDX,
    output logic          W_LAST,
    input  logic          LD_REQ,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_GNT,
    output logic          LD_ERR,
    output logic [AW-1:0] B_ADDR,
    output logic [DW-1:0] B_DI,
    output logic          B_EN,
    output logic          B_WE,
    input  logic [DW-1:0] B_DO
);

    // state | meaning
    // IDLE  | waiting; START wins over LD_REQ
    // READ  | issuing addresses 0..DEPTH-1, presenting the previous word
    // DRAIN | last word on the stream with DONE
    // WRITE | one-cycle loader write recovery
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    state_t        state_q,   state_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [DW-1:0] w_data_q,  w_data_d;
    logic          w_valid_q, w_valid_d;
    logic [AW-1:0] w_idx_q,   w_idx_d;
    logic          w_last_q,  w_last_d;
    logic          ld_gnt_q,  ld_gnt_d;
    logic          ld_err_q,  ld_err_d;
    logic [AW-1:0] b_addr_q,  b_addr_d;
    logic [DW-1:0] b_di_q,    b_di_d;
    logic          b_en_q,    b_en_d;
    logic          b_we_q,    b_we_d;

    logic          ld_addr_ok;

    assign ld_addr_ok = ({1'b0, LD_ADDR} < DEPTH_W);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        w_data_d  = w_data_q;
        w_valid_d = 1'b0;
        w_idx_d   = '0;
        w_last_d  = 1'b0;
        ld_gnt_d  = 1'b0;
        ld_err_d  = 1'b0;
        b_addr_d  = b_addr_q;
        b_di_d    = b_di_q;
        b_en_d    = 1'b0;
        b_we_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d  = S_READ;
                    busy_d   = 1'b1;
                    b_en_d   = 1'b1;
                    b_addr_d = '0;
                end else if (LD_REQ) begin
                    state_d  = S_WRITE;
                    ld_gnt_d = 1'b1;
                    if (ld_addr_ok) begin
                        b_en_d   = 1'b1;
                        b_we_d   = 1'b1;
                        b_addr_d = LD_ADDR;
                        b_di_d   = LD_DATA;
                    end else begin
                        ld_err_d = 1'b1;
                    end
                end
            end

            S_READ: begin
                // B_DO now holds the word for the address issued last edge
                w_valid_d = 1'b1;
                w_idx_d   = b_addr_q;
                w_data_d  = B_DO;
                if (b_addr_q == LAST_ADDR) begin
                    state_d  = S_DRAIN;
                    w_last_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    b_en_d   = 1'b1;
                    b_addr_d = b_addr_q + AW'(1);
                end
            end

            S_DRAIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
            w_last_q  <= 1'b0;
            ld_gnt_q  <= 1'b0;
            ld_err_q  <= 1'b0;
            b_addr_q  <= '0;
            b_di_q    <= '0;
            b_en_q    <= 1'b0;
            b_we_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
            w_idx_q   <= w_idx_d;
            w_last_q  <= w_last_d;
            ld_gnt_q  <= ld_gnt_d;
            ld_err_q  <= ld_err_d;
            b_addr_q  <= b_addr_d;
            b_di_q    <= b_di_d;
            b_en_q    <= b_en_d;
            b_we_q    <= b_we_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign W_DATA  = w_data_q;
    assign W_VALID = w_valid_q;
    assign W_IDX   = w_idx_q;
    assign W_LAST  = w_last_q;
    assign LD_GNT  = ld_gnt_q;
    assign LD_ERR  = ld_err_q;
    assign B_ADDR  = b_addr_q;
    assign B_DI    = b_di_q;
    assign B_EN    = b_en_q;
    assign B_WE    = b_we_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: negedge BRAM model, expected memory image as a plain array.
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          CLK, RST, START;
    logic          BUSY, DONE, W_VALID, W_LAST, LD_REQ, LD_GNT, LD_ERR, B_EN, B_WE;
    logic [DW-1:0] W_DATA, LD_DATA, B_DI, B_DO;
    logic [AW-1:0] W_IDX, LD_ADDR, B_ADDR;

    weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .W_DATA(W_DATA), .W_VALID(W_VALID), .W_IDX(W_IDX), .W_LAST(W_LAST),
        .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .LD_GNT(LD_GNT), .LD_ERR(LD_ERR),
        .B_ADDR(B_ADDR), .B_DI(B_DI), .B_EN(B_EN), .B_WE(B_WE), .B_DO(B_DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // BRAM: read-first, acts on the negedge
    logic [DW-1:0] bram  [DEPTH];
    logic [DW-1:0] model [DEPTH];

    always @(negedge CLK) begin
        if (B_EN && int'(B_ADDR) < DEPTH) begin
            B_DO <= bram[B_ADDR];
            if (B_WE) bram[B_ADDR] <= B_DI;
        end
    end

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            exp_err;
    } wr_vec_t;

    wr_vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] agg;
        agg = {31'(0), 1'b0} | 32'(BUSY) | 32'(DONE) << 1 | 32'(W_VALID) << 2 | 32'(W_LAST) << 3
            | 32'(LD_GNT) << 4 | 32'(LD_ERR) << 5 | 32'(B_EN) << 6 | 32'(B_WE) << 7;
        chk({tag, "_flags"}, agg, 0);
        chk({tag, "_w_data"}, 32'(W_DATA), 0);
        chk({tag, "_w_idx"}, 32'(W_IDX), 0);
        chk({tag, "_b_addr"}, 32'(B_ADDR), 0);
        chk({tag, "_b_di"}, 32'(B_DI), 0);
    endtask

    // Full burst starting in IDLE; on return the controller is back in IDLE.
    task automatic run_burst(input bit hold_start);
        START = 1'b1;
        step();
        chk("burst_busy_start", 32'(BUSY), 1);
        chk("burst_first_addr", {31'(0), B_EN} << 8 | 32'(B_ADDR), 32'h100);
        chk("burst_first_nodata", 32'(W_VALID), 0);
        if (!hold_start) START = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("burst_valid", 32'(W_VALID), 1);
            chk("burst_idx", 32'(W_IDX), 32'(k - 1));
            chk("burst_data", 32'(W_DATA), 32'(model[k - 1]));
            chk("burst_last", 32'(W_LAST), 32'(k == DEPTH));
            chk("burst_done", 32'(DONE), 32'(k == DEPTH));
            chk("burst_busy", 32'(BUSY), 1);
            chk("burst_no_wr", {30'(0), B_WE, LD_GNT}, 0);
            chk("burst_b_en", 32'(B_EN), 32'(k < DEPTH));
            if (k < DEPTH) chk("burst_b_addr", 32'(B_ADDR), 32'(k));
        end
        step();
        chk("post_burst_busy", 32'(BUSY), 0);
        chk("post_burst_stream", {29'(0), W_VALID, DONE, W_LAST}, 0);
        chk("post_burst_idx", 32'(W_IDX), 0);
        chk("post_burst_hold", 32'(W_DATA), 32'(model[DEPTH - 1]));
    endtask

    // Loader write; expected error flag supplied by the caller.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit exp_err, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        LD_REQ  = 1'b1;
        LD_ADDR = a;
        LD_DATA = d;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (LD_GNT) begin
                got    = 1'b1;
                waited = i;
                break;
            end
        end
        if (!got) begin
            chk("ld_gnt_timeout", 0, 1);
        end else begin
            chk("ld_err", 32'(LD_ERR), 32'(exp_err));
            chk("ld_b_en", 32'(B_EN), 32'(!exp_err));
            if (!exp_err) begin
                chk("ld_b_we", 32'(B_WE), 1);
                chk("ld_b_addr", 32'(B_ADDR), 32'(a));
                chk("ld_b_di", 32'(B_DI), 32'(d));
            end
        end
        LD_REQ = 1'b0;
        step();
        chk("ld_release", {28'(0), LD_GNT, LD_ERR, B_EN, B_WE}, 0);
        if (!exp_err && int'(a) < DEPTH) model[a] = d;
    endtask

    initial begin
        int waited;
        int bad;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        RST = 1'b1; START = 1'b0; LD_REQ = 1'b0; LD_ADDR = '0; LD_DATA = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]  = DW'(i * 16'h0101) ^ 16'h1234;
            model[i] = DW'(i * 16'h0101) ^ 16'h1234;
        end
        vecs[0] = '{5'd5,  16'hA5A5, 1'b0};
        vecs[1] = '{5'd28, 16'hDEAD, 1'b1};
        vecs[2] = '{5'd0,  16'h1111, 1'b0};
        vecs[3] = '{5'd27, 16'hFFFF, 1'b0};
        vecs[4] = '{5'd31, 16'hBEEF, 1'b1};
        vecs[5] = '{5'd29, 16'h0F0F, 1'b1};

        step();
        step();
        chk_all_zero("reset");
        RST = 1'b0;
        step();

        run_burst(1'b0);

        foreach (vecs[i]) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_err, waited);
            chk("ld_grant_latency", 32'(waited), 1);
        end
        run_burst(1'b0);

        // START and LD_REQ together: burst first, grant on first IDLE cycle after
        LD_REQ = 1'b1; LD_ADDR = 5'd3; LD_DATA = 16'h3C3C;
        run_burst(1'b0);
        do_write(5'd3, 16'h3C3C, 1'b0, waited);
        chk("gnt_after_done", 32'(waited), 1);
        run_burst(1'b0);

        // Reset at burst cycle 10
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 10; i++) step();
        RST = 1'b1;
        step();
        chk_all_zero("mid_reset");
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (W_VALID || DONE || B_EN || BUSY) bad++;
        end
        chk("no_activity_after_reset", 32'(bad), 0);
        run_burst(1'b0);

        // START held: back-to-back bursts with one idle cycle between them
        run_burst(1'b1);
        run_burst(1'b1);
        START = 1'b0;
        step();
        chk("held_start_released", 32'(BUSY), 0);

        // Random writes, including out-of-range addresses, then verify by burst
        for (int n = 0; n < 40; n++) begin
            ra = AW'($urandom_range(0, 31));
            rd = DW'($urandom);
            do_write(ra, rd, int'(ra) >= DEPTH, waited);
        end
        run_burst(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
